// File: rtl/idli_sqi_ctl_m.sv
// SQI memory controller: arbitrates instruction fetch and data load/store
// onto two nibble-wide SQI memories sharing one chip select.
//
// Ports:
//   i_sqi_gck, i_sqi_rst          clock, synchronous active-high reset
//   i_fetch_* / o_fetch_*         fetch read port (req/addr, ack, rvalid/rdata)
//   i_data_* / o_data_*           load/store port (req/wr/addr/wdata, ack, rvalid/rdata)
//   o_sqi_cs, o_sqi_oe            shared chip select (active low), SIO drive enable
//   o_sqi_sio, i_sqi_sio          SIO nibbles, [1] = high-nibble memory, [0] = low
//   o_busy                        high whenever a transaction is in flight
module idli_sqi_ctl_m #(
    parameter int unsigned DUMMY_CYC = 2
) (
    input  logic            i_sqi_gck,
    input  logic            i_sqi_rst,
    input  logic            i_fetch_req,
    input  logic [15:0]     i_fetch_addr,
    output logic            o_fetch_ack,
    output logic            o_fetch_rvalid,
    output logic [15:0]     o_fetch_rdata,
    input  logic            i_data_req,
    input  logic            i_data_wr,
    input  logic [15:0]     i_data_addr,
    input  logic [15:0]     i_data_wdata,
    output logic            o_data_ack,
    output logic            o_data_rvalid,
    output logic [15:0]     o_data_rdata,
    output logic            o_sqi_cs,
    output logic            o_sqi_oe,
    output logic [1:0][3:0] o_sqi_sio,
    input  logic [1:0][3:0] i_sqi_sio,
    output logic            o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_DESEL
    } state_e;

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYC - 1);

    state_e         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           f_ack_q, d_ack_q;
    logic           f_rv_q, d_rv_q;
    logic [15:0]    f_rd_q, d_rd_q;
    logic           cs_q, cs_d;
    logic           oe_q, oe_d;
    logic [1:0][3:0] sio_q, sio_d;
    logic           busy_q;
    logic           last_data_q;
    logic           port_q;
    logic           wr_q;
    logic [15:0]    addr_q;
    logic [15:0]    wdata_q;
    logic [7:0]     hi_q;

    logic           sample;
    logic           gnt_data, gnt_fetch;
    logic           cap_hi, fin_rd;
    logic [23:0]    byte_addr;
    logic [2:0]     nib_idx;
    logic [3:0]     nib;

    // The ack cycle is an IDLE cycle; the cycle after it enters CMD.
    // Requests are also sampled at the end of DESEL so the next grant
    // can land in the first IDLE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 3'd1;
        sample  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = 3'd0;
                sample = !(f_ack_q || d_ack_q);
                if (f_ack_q || d_ack_q) state_d = ST_CMD;
            end
            ST_CMD: if (cnt_q == 3'd1) begin
                state_d = ST_ADDR;
                cnt_d   = 3'd0;
            end
            ST_ADDR: if (cnt_q == 3'd5) begin
                state_d = wr_q ? ST_DATA : ST_DUMMY;
                cnt_d   = 3'd0;
            end
            ST_DUMMY: if (cnt_q == DUMMY_LAST) begin
                state_d = ST_DATA;
                cnt_d   = 3'd0;
            end
            ST_DATA: if (cnt_q == 3'd1) begin
                state_d = ST_DESEL;
                cnt_d   = 3'd0;
            end
            ST_DESEL: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
                sample  = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Round-robin: on a tie the port not granted last wins.
    assign gnt_data  = sample && i_data_req && (!i_fetch_req || !last_data_q);
    assign gnt_fetch = sample && i_fetch_req && !gnt_data;

    assign cap_hi = (state_q == ST_DATA) && !wr_q && (cnt_q == 3'd0);
    assign fin_rd = (state_q == ST_DATA) && !wr_q && (cnt_q == 3'd1);

    assign byte_addr = {7'b0, addr_q, 1'b0};
    assign nib_idx   = 3'd5 - cnt_d;
    assign nib       = byte_addr[{nib_idx, 2'b00} +: 4];

    // Pin values for the cycle being entered, registered below.
    always_comb begin
        cs_d  = 1'b1;
        oe_d  = 1'b0;
        sio_d = '0;
        unique case (state_d)
            ST_CMD: begin
                cs_d = 1'b0;
                oe_d = 1'b1;
                if (cnt_d == 3'd1) sio_d = {2{wr_q ? 4'h2 : 4'h3}};
            end
            ST_ADDR: begin
                cs_d  = 1'b0;
                oe_d  = 1'b1;
                sio_d = {nib, nib};
            end
            ST_DUMMY: cs_d = 1'b0;
            ST_DATA: begin
                cs_d = 1'b0;
                if (wr_q) begin
                    oe_d  = 1'b1;
                    sio_d = (cnt_d == 3'd0) ? wdata_q[15:8] : wdata_q[7:0];
                end
            end
            default: cs_d = 1'b1;
        endcase
    end

    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_rv_q      <= 1'b0;
            d_rv_q      <= 1'b0;
            f_rd_q      <= '0;
            d_rd_q      <= '0;
            cs_q        <= 1'b1;
            oe_q        <= 1'b0;
            sio_q       <= '0;
            busy_q      <= 1'b0;
            last_data_q <= 1'b0;
            port_q      <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hi_q        <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f_ack_q <= gnt_fetch;
            d_ack_q <= gnt_data;
            if (gnt_fetch || gnt_data) begin
                last_data_q <= gnt_data;
                port_q      <= gnt_data;
                wr_q        <= gnt_data && i_data_wr;
                addr_q      <= gnt_data ? i_data_addr : i_fetch_addr;
                wdata_q     <= i_data_wdata;
            end
            cs_q   <= cs_d;
            oe_q   <= oe_d;
            sio_q  <= sio_d;
            busy_q <= (state_d != ST_IDLE);
            if (cap_hi) hi_q <= i_sqi_sio;
            f_rv_q <= fin_rd && !port_q;
            d_rv_q <= fin_rd && port_q;
            if (fin_rd && !port_q) f_rd_q <= {hi_q, i_sqi_sio};
            if (fin_rd && port_q)  d_rd_q <= {hi_q, i_sqi_sio};
        end
    end

    assign o_fetch_ack    = f_ack_q;
    assign o_fetch_rvalid = f_rv_q;
    assign o_fetch_rdata  = f_rd_q;
    assign o_data_ack     = d_ack_q;
    assign o_data_rvalid  = d_rv_q;
    assign o_data_rdata   = d_rd_q;
    assign o_sqi_cs       = cs_q;
    assign o_sqi_oe       = oe_q;
    assign o_sqi_sio      = sio_q;
    assign o_busy         = busy_q;

endmodule
